// File: rtl/truth_table_sweeper_pkg.sv
// Shared sweeper definitions: FSM encoding, widths and the pattern-order encoder.
// SWEEP_GRAY_EN selects Gray-order visiting; undefined visits patterns in binary order.
package truth_table_sweeper_pkg;

  localparam int TT_NUM_PATTERNS = 8;
  localparam int TT_IDX_W        = 3;
  localparam int TT_TIMER_W      = 8;

  typedef enum logic [1:0] {
    TT_IDLE   = 2'd0,
    TT_SETTLE = 2'd1,
    TT_SAMPLE = 2'd2,
    TT_DONE   = 2'd3
  } tt_state_e;

  // Maps the sweep index to the pattern driven onto {a,b,c}.
  function automatic logic [TT_IDX_W-1:0] tt_pattern(input logic [TT_IDX_W-1:0] idx);
`ifdef SWEEP_GRAY_EN
    return idx ^ (idx >> 1);
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Per-pattern settle counter: clear, count-enable, terminal flag at SETTLE_CYCLES-1.
// Flag is combinational from the registered count; no backpressure.
module truth_table_sweeper_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [TT_TIMER_W-1:0] TC_VAL = TT_TIMER_W'(SETTLE_CYCLES - 1);

  logic [TT_TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + TT_TIMER_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 {a,b,c} patterns, samples y after a settle time and checks the truth table (SWEEP_GRAY_EN: Gray order).
// Done rises 8*(SETTLE_CYCLES+1)+1 clocks after start; start while busy is ignored.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'b1110_1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_y,
  output logic       o_a,
  output logic       o_b,
  output logic       o_c,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_table,
  output logic [7:0] o_err_mask
);

  localparam logic [TT_IDX_W-1:0] LAST_IDX = TT_IDX_W'(TT_NUM_PATTERNS - 1);

  tt_state_e                  state_q, state_d;
  logic [TT_IDX_W-1:0]        idx_q, idx_d;
  logic [TT_IDX_W-1:0]        pat_q, pat_d;
  logic [TT_NUM_PATTERNS-1:0] table_q, table_d;
  logic [TT_NUM_PATTERNS-1:0] err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       pass_q, pass_d;
  logic                       start_sweep;
  logic                       tmr_clr, tmr_en, tmr_tc;

  truth_table_sweeper_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (tmr_clr),
    .i_en   (tmr_en),
    .o_tc   (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pat_d       = pat_q;
    table_d     = table_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    start_sweep = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;

    case (state_q)
      TT_IDLE: start_sweep = i_start;
      TT_SETTLE: begin
        if (tmr_tc) state_d = TT_SAMPLE;
        else        tmr_en  = 1'b1;
      end
      TT_SAMPLE: begin
        table_d[pat_q] = i_y;
        tmr_clr        = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = TT_DONE;
        end else begin
          idx_d   = idx_q + TT_IDX_W'(1);
          pat_d   = tt_pattern(idx_q + TT_IDX_W'(1));
          state_d = TT_SETTLE;
        end
      end
      TT_DONE: begin
        // First DONE cycle publishes results from the completed table; restart only after that.
        if (!done_q) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          pass_d = (table_q == EXPECTED);
          err_d  = table_q ^ EXPECTED;
        end else begin
          start_sweep = i_start;
        end
      end
      default: state_d = TT_IDLE;
    endcase

    if (start_sweep) begin
      state_d = TT_SETTLE;
      idx_d   = '0;
      pat_d   = tt_pattern('0);
      table_d = '0;
      err_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      tmr_clr = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= TT_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      table_q <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      table_q <= table_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign o_a        = pat_q[2];
  assign o_b        = pat_q[1];
  assign o_c        = pat_q[0];
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_pass     = pass_q;
  assign o_table    = table_q;
  assign o_err_mask = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) each driving a table-lookup model block.
// Checks latency, pattern order, results, ignored mid-sweep start, reset abort and held-start restart.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start4, y4, a4, b4, c4, busy4, done4, pass4;
  logic [7:0] tbl4, mask4, func4;
  logic       start1, y1, a1, b1, c1, busy1, done1, pass1;
  logic [7:0] tbl1, mask1, func1;

  // Model of the block under exercise: y is the function's truth table looked up by {a,b,c}.
  assign y4 = func4[{a4, b4, c4}];
  assign y1 = func1[{a1, b1, c1}];

  truth_table_sweeper #(.SETTLE_CYCLES(4), .EXPECTED(8'hE8)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_y(y4),
    .o_a(a4), .o_b(b4), .o_c(c4), .o_busy(busy4), .o_done(done4),
    .o_pass(pass4), .o_table(tbl4), .o_err_mask(mask4)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hE8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_y(y1),
    .o_a(a1), .o_b(b1), .o_c(c1), .o_busy(busy1), .o_done(done1),
    .o_pass(pass1), .o_table(tbl1), .o_err_mask(mask1)
  );

  typedef struct {
    logic [7:0] func;
    logic [7:0] exp_table;
    logic       exp_pass;
    logic [7:0] exp_mask;
    string      name;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int order[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full sweep on the settle-4 instance; poke_at (1..40) re-pulses start mid-sweep, 0 = none.
  task automatic sweep4(input logic [7:0] f, input int poke_at, input logic [7:0] exp_t,
                        input logic exp_p, input logic [7:0] exp_m, input string tag);
    bit seq_ok;
    bit win_ok;
    int pi;
    seq_ok = 1'b1;
    win_ok = 1'b1;
    func4  = f;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int j = 0; j <= 40; j++) begin
      if (j > 0) begin
        if (j == poke_at) start4 = 1'b1;
        tick();
        start4 = 1'b0;
      end
      pi = (j / 5 > 7) ? 7 : j / 5;
      if ({a4, b4, c4} != 3'(order[pi])) seq_ok = 1'b0;
      if (!busy4 || done4) win_ok = 1'b0;
    end
    tick();
    chk({tag, "_pattern_seq"}, 32'(seq_ok), 32'd1);
    chk({tag, "_busy_window"}, 32'(win_ok), 32'd1);
    chk({tag, "_done_at_41"}, 32'(done4), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy4), 32'd0);
    chk({tag, "_table"}, 32'(tbl4), 32'(exp_t));
    chk({tag, "_pass"}, 32'(pass4), 32'(exp_p));
    chk({tag, "_err_mask"}, 32'(mask4), 32'(exp_m));
  endtask

  vec_t vecs[6];

  initial begin
    bit         seq_ok;
    bit         win_ok;
    int         pi;
    logic [7:0] f;
    int         poke;

`ifdef SWEEP_GRAY_EN
    order = '{0, 1, 3, 2, 6, 7, 5, 4};
`else
    order = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    vecs[0] = '{8'hE8, 8'hE8, 1'b1, 8'h00, "majority"};
    vecs[1] = '{8'hE0, 8'hE0, 1'b0, 8'h08, "maj_bad_row3"};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'hE8, "const0"};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h17, "const1"};
    vecs[4] = '{8'h96, 8'h96, 1'b0, 8'h7E, "xor3"};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h68, "and3"};

    rst_n  = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    func4  = 8'hE8;
    func1  = 8'hE8;
    #2;
    chk("reset_outputs4", {a4, b4, c4, busy4, done4, pass4, tbl4, mask4}, 32'd0);
    chk("reset_outputs1", {a1, b1, c1, busy1, done1, pass1, tbl1, mask1}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", {busy4, done4}, 32'd0);

    foreach (vecs[i]) sweep4(vecs[i].func, 0, vecs[i].exp_table, vecs[i].exp_pass, vecs[i].exp_mask, vecs[i].name);

    // Start re-pulsed at cycle 15 must not disturb timing or results.
    sweep4(8'hE8, 15, 8'hE8, 1'b1, 8'h00, "mid_start");

    // Reset at cycle 20 aborts the sweep with a non-empty partial table.
    func4  = 8'hE8;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (20) tick();
    chk("pre_reset_busy", 32'(busy4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_abort", {a4, b4, c4, busy4, done4, pass4, tbl4, mask4}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {busy4, done4, tbl4}, 32'd0);
    sweep4(8'hE8, 0, 8'hE8, 1'b1, 8'h00, "after_reset");

    // Random functions against the reference: table is the function itself, pass iff equal to majority.
    for (int r = 0; r < 10; r++) begin
      f    = 8'($urandom);
      if (r == 3) f = 8'hE8;
      poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
      sweep4(f, poke, f, (f == 8'hE8), f ^ 8'hE8, "rand");
      repeat ($urandom_range(0, 5)) tick();
      chk("rand_done_holds", {done4, tbl4}, {24'd0, 1'b1, f});
    end

    // Settle 1 with start held high: 2 cycles per pattern, done at 17, then immediate restart.
    start1 = 1'b1;
    tick();
    seq_ok = 1'b1;
    win_ok = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) tick();
      pi = (j / 2 > 7) ? 7 : j / 2;
      if ({a1, b1, c1} != 3'(order[pi])) seq_ok = 1'b0;
      if (!busy1 || done1) win_ok = 1'b0;
    end
    chk("s1_pattern_seq", 32'(seq_ok), 32'd1);
    chk("s1_busy_window", 32'(win_ok), 32'd1);
    tick();
    chk("s1_done_at_17", {done1, busy1, pass1, tbl1, mask1}, {21'd0, 1'b1, 1'b0, 1'b1, 8'hE8, 8'h00});
    tick();
    chk("s1_restart", {done1, busy1, a1, b1, c1}, {27'd0, 1'b0, 1'b1, 3'd0});
    start1 = 1'b0;
    repeat (16) tick();
    chk("s1_second_not_early", 32'(done1), 32'd0);
    tick();
    chk("s1_second_done", {done1, pass1, tbl1}, {22'd0, 1'b1, 1'b1, 8'hE8});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
